// File: rtl/integrity_result_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : integrity_result_monitor                                     |
// | Description : Latches a sticky verdict (PASS / FAIL_DATA / FAIL_LOST /      |
// |               FAIL_TIMEOUT) from the data-integrity scoreboard outputs.     |
// |               Optional macro INTEGRITY_MONITOR_TIMEOUT_EN adds the          |
// |               capture-to-exit cycle bound.                                  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module integrity_result_monitor #(
    parameter int DEPTH   = 8,
    parameter int CNTWID  = $clog2(DEPTH) + 1,
    parameter int TIMEOUT = 64,
    parameter int TOWID   = $clog2(TIMEOUT) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              start,
    input  logic              data_out_vld,
    input  logic              prop_signal,
    output logic [2:0]        state,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [CNTWID-1:0] pop_cnt,
    output logic [TOWID-1:0]  cyc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRACK = 3'd1,
        S_PASS  = 3'd2,
        S_FAIL  = 3'd3
    } state_t;

    localparam logic [1:0]        c_code_none = 2'd0;
    localparam logic [1:0]        c_code_data = 2'd1;
    localparam logic [1:0]        c_code_lost = 2'd2;
    localparam logic [1:0]        c_code_to   = 2'd3;
    localparam logic [CNTWID-1:0] c_pop_last  = CNTWID'(DEPTH - 1);
    localparam logic [CNTWID-1:0] c_pop_max   = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0] c_pop_one   = CNTWID'(1);

    generate
        if (CNTWID < $clog2(DEPTH + 1)) begin : g_cntwid_chk
            $error("CNTWID cannot represent DEPTH");
        end
        if (TOWID < $clog2(TIMEOUT + 1)) begin : g_towid_chk
            $error("TOWID cannot represent TIMEOUT");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [1:0]        code_q, code_d;
    logic [CNTWID-1:0] pop_q, pop_d;
    logic              w_capture;
    logic              w_timeout;

    assign w_capture = (state_q == S_IDLE) && start && push;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pop_d   = pop_q;
        case (state_q)
            S_IDLE: begin
                if (w_capture) begin
                    state_d = S_TRACK;
                    pop_d   = '0;
                end
            end
            S_TRACK: begin
                // Exit beats LOST, LOST beats TIMEOUT
                if (data_out_vld && prop_signal) begin
                    state_d = S_PASS;
                end else if (data_out_vld) begin
                    state_d = S_FAIL;
                    code_d  = c_code_data;
                end else if (pop && (pop_q == c_pop_last)) begin
                    state_d = S_FAIL;
                    code_d  = c_code_lost;
                end else if (w_timeout) begin
                    state_d = S_FAIL;
                    code_d  = c_code_to;
                end else if (pop && (pop_q != c_pop_max)) begin
                    pop_d = pop_q + c_pop_one;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= c_code_none;
            pop_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pop_q   <= pop_d;
        end
    end

`ifdef INTEGRITY_MONITOR_TIMEOUT_EN
    localparam logic [TOWID-1:0] c_cyc_last = TOWID'(TIMEOUT - 1);
    localparam logic [TOWID-1:0] c_cyc_max  = TOWID'(TIMEOUT);
    localparam logic [TOWID-1:0] c_cyc_one  = TOWID'(1);

    logic [TOWID-1:0] cyc_q;
    logic             w_hold;

    // Cycle counter advances only while tracking continues without a verdict
    assign w_hold    = (state_q == S_TRACK) && (state_d == S_TRACK);
    assign w_timeout = (cyc_q == c_cyc_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (w_capture) begin
            cyc_q <= '0;
        end else if (w_hold && (cyc_q != c_cyc_max)) begin
            cyc_q <= cyc_q + c_cyc_one;
        end
    end

    assign cyc_cnt = cyc_q;
`else
    assign w_timeout = 1'b0;
    assign cyc_cnt   = '0;
`endif

    assign state     = state_q;
    assign done      = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass      = (state_q == S_PASS);
    assign fail_code = code_q;
    assign pop_cnt   = pop_q;

endmodule
`default_nettype wire

// File: doc/integrity_result_monitor.md
Name: integrity_result_monitor

Overview:
- Downstream consumer of the data-integrity scoreboard: takes its data_out_vld / prop_signal outputs plus the FIFO push/pop/start controls.
- Reduces them to a sticky verdict: PASS, FAIL_DATA, FAIL_LOST or FAIL_TIMEOUT.
- Adds a bounded-delivery check: a captured magic packet must exit within DEPTH pops.
- Gives benches and formal harnesses one latched result instead of a per-cycle property.

Parameters:
DEPTH, 8, FIFO depth; the magic packet must exit within DEPTH pops after capture
CNTWID, $clog2(DEPTH)+1, pop counter width (must hold the value DEPTH)
TIMEOUT, 64, cycle bound from capture to exit (used only with the optional feature)
TOWID, $clog2(TIMEOUT)+1, cycle counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
push  input  1  FIFO push, same signal driven to the scoreboard
pop  input  1  FIFO pop, same signal driven to the scoreboard
start  input  1  scoreboard start; capture occurs on start & push
data_out_vld  input  1  scoreboard: magic packet exiting this cycle
prop_signal  input  1  scoreboard: data-match property, only meaningful when data_out_vld=1
state  output  3  IDLE=0, TRACK=1, PASS=2, FAIL=3
done  output  1  state is PASS or FAIL
pass  output  1  state is PASS
fail_code  output  2  0=none, 1=DATA, 2=LOST, 3=TIMEOUT
pop_cnt  output  CNTWID  pops counted since capture, saturates at DEPTH
cyc_cnt  output  TOWID  cycles since capture, saturates at TIMEOUT; reads 0 when the feature is compiled out

Behaviour:
- Reset and output values:
  - The design has one clock (clk). Reset (rst) is synchronous and active-high.
  - While rst=1 at a clock edge: state=IDLE, fail_code=0, pop_cnt=0, cyc_cnt=0, done=0, pass=0.
  - rst takes priority over every other input, including in TRACK and the terminal states.
- Output timing: all outputs are registered; done and pass decode state directly.
- IDLE:
  - start & push moves to TRACK next cycle and clears both counters.
  - A pop in the capture cycle is not counted.
  - data_out_vld in IDLE is ignored.
- TRACK, evaluated in this priority each cycle:
  1. data_out_vld & prop_signal goes to PASS.
  2. data_out_vld & ~prop_signal goes to FAIL with fail_code=1.
  3. pop with pop_cnt==DEPTH-1 goes to FAIL with fail_code=2: the DEPTH-th pop occurred without an exit.
  4. Timeout check (feature only): cyc_cnt==TIMEOUT-1 goes to FAIL with fail_code=3.
  5. Otherwise pop increments pop_cnt, and cyc_cnt increments (feature only).
- Simultaneous events:
  - Exit wins over LOST and TIMEOUT in the same cycle.
  - LOST wins over TIMEOUT.
- In TRACK, start & push is ignored; only one magic packet is tracked.
- PASS and FAIL are sticky until rst; counters freeze at their final values.
- Counters never wrap. pop_cnt width must represent DEPTH; an elaboration check errors if it cannot.
- Latency:
  - A verdict is visible one cycle after the deciding input cycle.
  - Capture appears as state=TRACK one cycle after start & push.

Optional Feature:
- Macro: INTEGRITY_MONITOR_TIMEOUT_EN.
- When defined:
  - cyc_cnt counter is instantiated.
  - The TIMEOUT check (priority 4) is active.
  - Detects liveness loss when pops stall indefinitely.
- When undefined:
  - No cycle counter; cyc_cnt is tied to 0.
  - fail_code=3 is never produced.
  - TRACK is left only on exit, LOST, or rst.

Test Plan:
- Nominal: rst 2 cycles; push data 0xA5 with start=1 into an empty FIFO; pop next cycle, scoreboard drives data_out_vld=1, prop_signal=1 -> state=PASS, pass=1, pop_cnt=0, fail_code=0 one cycle later.
- Data corruption: capture, then 3 pops; on the 3rd pop data_out_vld=1, prop_signal=0 -> state=FAIL, fail_code=1, pop_cnt=2.
- Lost packet: DEPTH=8, capture, then 8 pops with data_out_vld held 0 -> FAIL, fail_code=2 after the 8th pop, pop_cnt=7; 7 pops alone leave the state in TRACK.
- Priority: 8th pop coincides with data_out_vld=1, prop_signal=1 -> PASS (exit beats LOST). With the macro and TIMEOUT=8: 7 idle cycles, then a cycle with pop_cnt==DEPTH-1 & pop & cyc_cnt==7 -> fail_code=2, not 3.
- Timeout (macro defined, TIMEOUT=16): capture, no pops for 16 cycles -> FAIL, fail_code=3, cyc_cnt=15. Macro undefined: state remains TRACK after 100 cycles, cyc_cnt=0.
- Reset mid-op and stickiness: rst pulsed in TRACK with pop_cnt=4 -> IDLE, counters 0. After PASS, further start & push and data_out_vld pulses do not change state, fail_code or counters.
